// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle between the serial pin and the consumer of
// received words.
//   uart_rxd          serial line (asynchronous to clk, idle high)
//   uart_rx_en        receive enable
//   uart_rx_valid     one-cycle strobe, uart_rx_data holds a new word
//   uart_rx_data      last good word
//   uart_rx_frame_err one-cycle strobe, stop bit sampled low
//   uart_rx_break     one-cycle strobe, frame error with all-zero payload
// Modports: master = line/consumer side, slave = the receiver.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver. Synchronizes the rxd pin, samples each
// bit at its nominal midpoint and reassembles LSB-first payloads.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     uart_rx_if.slave: rxd/enable in; valid, data, frame_err, break out
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     resetn,
  uart_rx_if.slave bus
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = 1 + $clog2(CYCLES_PER_BIT);
  localparam int BW             = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

  localparam logic [CW-1:0] LP_HALF     = CW'(HALF_BIT);
  localparam logic [CW-1:0] LP_BIT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LP_DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LP_STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  r_state;
  logic                    r_sync1;
  logic                    r_sync2;
  logic [CW-1:0]           r_cnt;
  logic [BW-1:0]           r_bits;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_stop_err;
  logic                    r_valid;
  logic                    r_ferr;
  logic                    r_break;
  logic [PAYLOAD_BITS-1:0] r_data;

  logic                    w_rxd_s;
  logic                    w_half;
  logic                    w_bit_done;
  logic                    w_frame_err;
  logic [PAYLOAD_BITS-1:0] w_shift_in;

  assign w_rxd_s     = r_sync2;
  assign w_half      = (r_cnt == LP_HALF);
  assign w_bit_done  = (r_cnt == LP_BIT_LAST);
  // Includes the current stop sample so a low final stop bit counts.
  assign w_frame_err = r_stop_err | ~w_rxd_s;

  // New bit enters at the MSB; after PAYLOAD_BITS shifts bit 0 is the first bit.
  always_comb begin
    w_shift_in                   = r_shift >> 1;
    w_shift_in[PAYLOAD_BITS-1]   = w_rxd_s;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_stop_err <= 1'b0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_break    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_break <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.uart_rx_en && !w_rxd_s) r_state <= START;
        end
        START: begin
          if (w_half) begin
            r_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= IDLE;
            end else begin
              r_state <= RECV;
              r_bits  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RECV: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_shift <= w_shift_in;
            if (r_bits == LP_DATA_LAST) begin
              r_state    <= STOP;
              r_bits     <= '0;
              r_stop_err <= 1'b0;
            end else begin
              r_bits <= r_bits + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bits == LP_STOP_LAST) begin
              if (w_frame_err) begin
                r_ferr  <= 1'b1;
                r_break <= (r_shift == '0);
                r_state <= WAIT_HIGH;
              end else begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
                r_state <= IDLE;
              end
            end else begin
              r_stop_err <= w_frame_err;
              r_bits     <= r_bits + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rxd_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.uart_rx_valid     = r_valid;
  assign bus.uart_rx_data      = r_data;
  assign bus.uart_rx_frame_err = r_ferr;
  assign bus.uart_rx_break     = r_break;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  int   cyc;

  // Output event record, sampled on the falling edge.
  int          n_valid;
  int          n_err;
  int          n_brk;
  int          n_both;
  int          n_bad_chg;
  int          last_valid_cyc;
  int          prev_valid_cyc;
  logic [7:0]  last_data;
  logic [7:0]  prev_data;
  logic [7:0]  seen_data;

  uart_rx_if #(.PAYLOAD_BITS(8)) bus ();

  uart_rx #(
    .BIT_RATE    (100_000),
    .CLK_HZ      (1_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_valid = 0; n_err = 0; n_brk = 0; n_both = 0; n_bad_chg = 0;
    last_valid_cyc = 0; prev_valid_cyc = 0;
    last_data = '0; prev_data = '0; seen_data = '0;
  end

  always @(negedge clk) begin
    if (bus.uart_rx_valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      prev_data      = last_data;
      last_data      = bus.uart_rx_data;
    end
    if (bus.uart_rx_frame_err) n_err++;
    if (bus.uart_rx_break) n_brk++;
    if (bus.uart_rx_valid && bus.uart_rx_frame_err) n_both++;
    if (bus.uart_rx_data !== seen_data && !bus.uart_rx_valid) n_bad_chg++;
    seen_data = bus.uart_rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.uart_rxd = b;
    idle(10);
  endtask

  // Start bit, LSB-first payload, one stop bit; enable drops before bit drop_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int drop_at);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == drop_at) bus.uart_rx_en = 1'b0;
      drive_bit(f[i]);
    end
  endtask

  int n0, v0, e0, b0;

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    bus.uart_rxd = 1'b1;
    bus.uart_rx_en = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    check("reset_valid", 32'(bus.uart_rx_valid), 32'd0);
    check("reset_data", 32'(bus.uart_rx_data), 32'h00);
    check("reset_ferr", 32'(bus.uart_rx_frame_err), 32'd0);
    check("reset_break", 32'(bus.uart_rx_break), 32'd0);
    resetn = 1'b1;
    idle(5);

    // Single good frame with exact strobe timing.
    v0 = n_valid; e0 = n_err;
    n0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    idle(20);
    check("a5_count", 32'(n_valid - v0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_time", 32'(last_valid_cyc - n0), 32'd99);
    check("a5_no_err", 32'(n_err - e0), 32'd0);

    // Back-to-back frames, no idle gap.
    v0 = n_valid;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(20);
    check("b2b_count", 32'(n_valid - v0), 32'd2);
    check("b2b_data0", 32'(prev_data), 32'h00);
    check("b2b_data1", 32'(last_data), 32'hFF);
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd100);

    // Short low glitch on an idle line.
    v0 = n_valid; e0 = n_err;
    bus.uart_rxd = 1'b0;
    idle(3);
    bus.uart_rxd = 1'b1;
    idle(40);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_no_err", 32'(n_err - e0), 32'd0);
    check("glitch_data", 32'(bus.uart_rx_data), 32'hFF);

    // Good 0x11, then 0x3C with low stop bit; line stays low a while.
    v0 = n_valid; e0 = n_err; b0 = n_brk;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h3C, 1'b0, -1);
    idle(30);
    bus.uart_rxd = 1'b1;
    idle(20);
    check("ferr_valid_count", 32'(n_valid - v0), 32'd1);
    check("ferr_count", 32'(n_err - e0), 32'd1);
    check("ferr_no_break", 32'(n_brk - b0), 32'd0);
    check("ferr_data_kept", 32'(bus.uart_rx_data), 32'h11);

    // Line break for 20 bit-times, then a good frame.
    v0 = n_valid; e0 = n_err; b0 = n_brk;
    bus.uart_rxd = 1'b0;
    idle(200);
    bus.uart_rxd = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, -1);
    idle(20);
    check("brk_err_count", 32'(n_err - e0), 32'd1);
    check("brk_count", 32'(n_brk - b0), 32'd1);
    check("brk_valid_count", 32'(n_valid - v0), 32'd1);
    check("brk_then_data", 32'(last_data), 32'h5A);

    check("valid_err_overlap", 32'(n_both), 32'd0);
    check("data_chg_no_valid", 32'(n_bad_chg), 32'd0);

    // Enable low for a whole frame.
    v0 = n_valid;
    bus.uart_rx_en = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    idle(20);
    bus.uart_rx_en = 1'b1;
    idle(5);
    check("en_off_count", 32'(n_valid - v0), 32'd0);
    check("en_off_data", 32'(bus.uart_rx_data), 32'h5A);

    // Enable dropped mid-frame.
    v0 = n_valid;
    send_frame(8'h96, 1'b1, 3);
    idle(20);
    bus.uart_rx_en = 1'b1;
    check("en_drop_count", 32'(n_valid - v0), 32'd1);
    check("en_drop_data", 32'(last_data), 32'h96);

    // Reset in the middle of the payload.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    resetn = 1'b0;
    #1;
    check("rst_mid_data", 32'(bus.uart_rx_data), 32'h00);
    check("rst_mid_valid", 32'(bus.uart_rx_valid), 32'd0);
    check("rst_mid_ferr", 32'(bus.uart_rx_frame_err), 32'd0);
    check("rst_mid_break", 32'(bus.uart_rx_break), 32'd0);
    bus.uart_rxd = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(5);
    v0 = n_valid;
    send_frame(8'h3C, 1'b1, -1);
    idle(20);
    check("post_rst_count", 32'(n_valid - v0), 32'd1);
    check("post_rst_data", 32'(last_data), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
